// File: rtl/commit_trace_recorder.sv
// Commit trace recorder: captures GPR, HI/LO and store events with a cycle stamp
// into a multi-push circular FIFO drained one record per cycle over valid/ready.
module commit_trace_recorder #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       reg_we_i,
    input  logic [4:0]                 reg_waddr_i,
    input  logic [31:0]                reg_wdata_i,
    input  logic                       hilo_we_i,
    input  logic [63:0]                hilo_wdata_i,
    input  logic                       mem_we_i,
    input  logic [15:0]                mem_addr_i,
    input  logic [31:0]                mem_wdata_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [1:0]                 out_kind_o,
    output logic [15:0]                out_addr_o,
    output logic [63:0]                out_data_o,
    output logic [CNT_W-1:0]           out_cycle_o,
    output logic                       overflow_o,
    output logic [CNT_W-1:0]           drop_count_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 2;

    logic [1:0]       kind_mem  [DEPTH];
    logic [15:0]      addr_mem  [DEPTH];
    logic [63:0]      data_mem  [DEPTH];
    logic [CNT_W-1:0] stamp_mem [DEPTH];

    logic [AW:0]      wr_q, rd_q;
    logic [CNT_W-1:0] cycle_q, drop_q;
    logic             overflow_q;

    logic [AW:0]      level;
    logic             valid, pop;
    logic [1:0]       c_kind [3];
    logic [15:0]      c_addr [3];
    logic [63:0]      c_data [3];
    logic [AW-1:0]    w_idx  [3];
    logic [1:0]       n_ev, n_push, n_drop;
    logic [FW-1:0]    free;
    logic [CNT_W:0]   drop_sum;

    always_comb begin
        level = wr_q - rd_q;
        valid = (level != '0);
        pop   = valid && out_ready_i;

        for (int i = 0; i < 3; i++) begin
            c_kind[i] = '0;
            c_addr[i] = '0;
            c_data[i] = '0;
            w_idx[i]  = wr_q[AW-1:0] + AW'(i);
        end
        n_ev = '0;
        // Compact qualified events into insertion order GPR, HILO, MEM
        if (reg_we_i && (reg_waddr_i != 5'd0)) begin
            c_kind[n_ev] = 2'd0;
            c_addr[n_ev] = {11'b0, reg_waddr_i};
            c_data[n_ev] = {32'b0, reg_wdata_i};
            n_ev         = n_ev + 2'd1;
        end
        if (hilo_we_i) begin
            c_kind[n_ev] = 2'd1;
            c_addr[n_ev] = 16'h0000;
            c_data[n_ev] = hilo_wdata_i;
            n_ev         = n_ev + 2'd1;
        end
        if (mem_we_i) begin
            c_kind[n_ev] = 2'd2;
            c_addr[n_ev] = mem_addr_i;
            c_data[n_ev] = {32'b0, mem_wdata_i};
            n_ev         = n_ev + 2'd1;
        end

        free     = FW'(DEPTH) - FW'(level) + FW'(pop);
        n_push   = (FW'(n_ev) > free) ? free[1:0] : n_ev;
        n_drop   = n_ev - n_push;
        drop_sum = {1'b0, drop_q} + (CNT_W+1)'(n_drop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cycle_q    <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            rd_q    <= rd_q + (AW+1)'(pop);
            wr_q    <= wr_q + (AW+1)'(n_push);
            if (n_drop != 2'd0) begin
                overflow_q <= 1'b1;
                drop_q     <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            end
        end
    end

    // Storage carries no reset; outputs are masked while empty instead
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < 3; k++) begin
                if (k < int'(n_push)) begin
                    kind_mem[w_idx[k]]  <= c_kind[k];
                    addr_mem[w_idx[k]]  <= c_addr[k];
                    data_mem[w_idx[k]]  <= c_data[k];
                    stamp_mem[w_idx[k]] <= cycle_q;
                end
            end
        end
    end

    assign out_valid_o  = valid;
    assign out_kind_o   = valid ? kind_mem[rd_q[AW-1:0]]  : '0;
    assign out_addr_o   = valid ? addr_mem[rd_q[AW-1:0]]  : '0;
    assign out_data_o   = valid ? data_mem[rd_q[AW-1:0]]  : '0;
    assign out_cycle_o  = valid ? stamp_mem[rd_q[AW-1:0]] : '0;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;
    assign level_o      = level;

endmodule

// File: tb/tb_commit_trace_recorder.sv
// Scoreboard bench for commit_trace_recorder: stimulus queues expected records,
// a negedge monitor pops and compares every accepted record.
module tb_commit_trace_recorder;

    localparam int DEPTH = 16;
    localparam int CNT_W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_we, hilo_we, mem_we, out_ready;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata, mem_wdata;
    logic [63:0] hilo_wdata;
    logic [15:0] mem_addr;
    logic        out_valid, overflow;
    logic [1:0]  out_kind;
    logic [15:0] out_addr;
    logic [63:0] out_data;
    logic [CNT_W-1:0] out_cycle, drop_count;
    logic [$clog2(DEPTH):0] level;

    commit_trace_recorder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .reg_we_i(reg_we), .reg_waddr_i(reg_waddr), .reg_wdata_i(reg_wdata),
        .hilo_we_i(hilo_we), .hilo_wdata_i(hilo_wdata),
        .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_kind_o(out_kind), .out_addr_o(out_addr), .out_data_o(out_data),
        .out_cycle_o(out_cycle), .overflow_o(overflow),
        .drop_count_o(drop_count), .level_o(level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [63:0] data;
        logic [31:0] cyc;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tb_cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_record: got kind %0d addr 0x%0h data 0x%0h cycle %0d, expected none",
                         out_kind, out_addr, out_data, out_cycle);
            end else begin
                mon_e = exp_q.pop_front();
                check("rec_kind",  64'(out_kind),  64'(mon_e.kind));
                check("rec_addr",  64'(out_addr),  64'(mon_e.addr));
                check("rec_data",  out_data,       mon_e.data);
                check("rec_cycle", 64'(out_cycle), 64'(mon_e.cyc));
            end
        end
    end

    task automatic clear_inputs();
        reg_we = 0; reg_waddr = '0; reg_wdata = '0;
        hilo_we = 0; hilo_wdata = '0;
        mem_we = 0; mem_addr = '0; mem_wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tb_cyc++;
    endtask

    // Drive one cycle of events; 'accept' is the hand-computed number admitted
    task automatic ev(input logic g, input logic [4:0] ga, input logic [31:0] gd,
                      input logic h, input logic [63:0] hd,
                      input logic m, input logic [15:0] ma, input logic [31:0] md,
                      input int accept);
        int n;
        n = 0;
        reg_we = g; reg_waddr = ga; reg_wdata = gd;
        hilo_we = h; hilo_wdata = hd;
        mem_we = m; mem_addr = ma; mem_wdata = md;
        if (g && ga != 5'd0 && n < accept) begin
            exp_q.push_back('{kind: 2'd0, addr: {11'b0, ga}, data: {32'b0, gd}, cyc: 32'(tb_cyc)});
            n++;
        end
        if (h && n < accept) begin
            exp_q.push_back('{kind: 2'd1, addr: 16'h0, data: hd, cyc: 32'(tb_cyc)});
            n++;
        end
        if (m && n < accept) begin
            exp_q.push_back('{kind: 2'd2, addr: ma, data: {32'b0, md}, cyc: 32'(tb_cyc)});
            n++;
        end
        step();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tb_cyc = 0;

        check("reset_valid",    64'(out_valid),  64'd0);
        check("reset_level",    64'(level),      64'd0);
        check("reset_overflow", 64'(overflow),   64'd0);
        check("reset_drops",    64'(drop_count), 64'd0);
        check("reset_kind",     64'(out_kind),   64'd0);
        check("reset_addr",     64'(out_addr),   64'd0);
        check("reset_data",     out_data,        64'd0);
        check("reset_cycle",    64'(out_cycle),  64'd0);

        // Single GPR write in cycle 5
        out_ready = 1'b1;
        while (tb_cyc < 5) step();
        ev(1, 5'd3, 32'h0000_1234, 0, '0, 0, '0, '0, 1);
        check("gpr_valid", 64'(out_valid), 64'd1);
        check("gpr_level", 64'(level),     64'd1);
        step();
        check("gpr_drained", 64'(level), 64'd0);

        // Three events in one cycle, held then drained
        out_ready = 1'b0;
        ev(1, 5'd2, 32'hA, 1, 64'h1_0000_0002, 1, 16'h0010, 32'hB, 3);
        check("triple_level", 64'(level), 64'd3);
        out_ready = 1'b1;
        repeat (3) step();
        check("triple_drained", 64'(level), 64'd0);

        // Write to $0 is ignored
        ev(1, 5'd0, 32'hDEAD, 0, '0, 0, '0, '0, 0);
        check("r0_level",    64'(level),     64'd0);
        check("r0_valid",    64'(out_valid), 64'd0);
        check("r0_overflow", 64'(overflow),  64'd0);

        // Fill to full, 17th dropped, then three more dropped
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++)
            ev(1, 5'(i + 1), 32'h100 + 32'(i), 0, '0, 0, '0, '0, (i < 16) ? 1 : 0);
        check("full_level",    64'(level),      64'd16);
        check("full_overflow", 64'(overflow),   64'd1);
        check("full_drops",    64'(drop_count), 64'd1);
        ev(1, 5'd9, 32'h9, 1, 64'h5, 1, 16'h4, 32'h4, 0);
        check("full_triple_drops", 64'(drop_count), 64'd4);
        check("full_triple_level", 64'(level),      64'd16);

        // Full with concurrent pop: freed slot takes the store
        out_ready = 1'b1;
        ev(0, '0, '0, 0, '0, 1, 16'h0020, 32'hCAFE, 1);
        check("fullpop_level", 64'(level),      64'd16);
        check("fullpop_drops", 64'(drop_count), 64'd4);
        repeat (16) step();
        check("fullpop_drained", 64'(level), 64'd0);

        // Reset mid-drain discards buffered records and the colliding event
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            ev(1, 5'(i + 20), 32'h500 + 32'(i), 0, '0, 0, '0, '0, 1);
        check("prereset_level", 64'(level), 64'd5);
        rst = 1'b0;
        out_ready = 1'b1;
        mem_we = 1'b1; mem_addr = 16'h0BAD; mem_wdata = 32'hBAD;
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_inputs();
        exp_q.delete();
        tb_cyc = 0;
        check("midreset_valid",    64'(out_valid),  64'd0);
        check("midreset_level",    64'(level),      64'd0);
        check("midreset_overflow", 64'(overflow),   64'd0);
        check("midreset_drops",    64'(drop_count), 64'd0);
        ev(1, 5'd7, 32'h77, 0, '0, 0, '0, '0, 1);
        check("postreset_valid", 64'(out_valid), 64'd1);
        repeat (3) step();
        check("postreset_level", 64'(level), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
